// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response codes, handshake FSM states and byte-strobe helpers
package axi4_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int k = 0; k < 4; k++)
            res[8*k +: 8] = strb[k] ? data[8*k +: 8] : old[8*k +: 8];
        return res;
    endfunction

    // offset is addr - base; a wrapped (below-base) address lands in the upper bits too
    function automatic logic [1:0] decode_resp(input logic [31:0] offset, input int num_regs);
        return (offset[31:12] != '0) ? RESP_DECERR :
               ({22'd0, offset[11:2]} >= 32'(num_regs)) ? RESP_SLVERR : RESP_OKAY;
    endfunction
endpackage

// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile: AXI4-Lite register bank with independent write/read handshake FSMs
module axi4_lite_slave_regfile
    import axi4_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
    parameter int          NUM_REGS  = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [31:0]              awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [31:0]              araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [32*NUM_REGS-1:0]   regs_out
);
    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic        ready_en;
    logic        aw_fire, w_fire, ar_fire, w_commit;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [31:0] c_addr, c_data, c_off, r_off, r_val;
    logic [3:0]  c_strb;
    logic [1:0]  c_resp, r_resp_d;
    logic [31:0] regs [NUM_REGS];
    logic        unused_prot;

    assign unused_prot = ^{awprot, arprot};

    always_comb begin
        awready  = ready_en && (w_state == W_IDLE || w_state == W_HAVE_DATA);
        wready   = ready_en && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
        bvalid   = w_state == W_RESP;
        aw_fire  = awvalid && awready;
        w_fire   = wvalid && wready;
        w_commit = (w_state == W_IDLE && aw_fire && w_fire) ||
                   (w_state == W_HAVE_ADDR && w_fire) ||
                   (w_state == W_HAVE_DATA && aw_fire);
        w_next   = w_commit                           ? W_RESP :
                   (w_state == W_RESP && bready)      ? W_IDLE :
                   (w_state == W_IDLE && aw_fire)     ? W_HAVE_ADDR :
                   (w_state == W_IDLE && w_fire)      ? W_HAVE_DATA : w_state;
        c_addr   = aw_fire ? awaddr : aw_addr_q;
        c_data   = w_fire ? wdata : w_data_q;
        c_strb   = w_fire ? wstrb : w_strb_q;
        c_off    = c_addr - BASE_ADDR;
        c_resp   = decode_resp(c_off, NUM_REGS);
    end

    always_comb begin
        arready  = ready_en && r_state == R_IDLE;
        rvalid   = r_state == R_RESP;
        ar_fire  = arvalid && arready;
        r_next   = ar_fire ? R_RESP : (r_state == R_RESP && rready) ? R_IDLE : r_state;
        r_off    = araddr - BASE_ADDR;
        r_resp_d = decode_resp(r_off, NUM_REGS);
        r_val    = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r_off[11:2] == i[9:0]) r_val = regs[i];
    end

    // readys stay low until the first edge after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en <= 1'b0;
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
        end else begin
            ready_en <= 1'b1;
            w_state  <= w_next;
            r_state  <= r_next;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= RESP_OKAY;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
        end else begin
            if (aw_fire) aw_addr_q <= awaddr;
            if (w_fire) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (w_commit) bresp <= c_resp;
            if (ar_fire) begin
                rdata <= (r_resp_d == RESP_OKAY) ? r_val : '0;
                rresp <= r_resp_d;
            end
        end
    end

    // a same-edge read samples the pre-write value through the nonblocking update
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (w_commit && c_resp == RESP_OKAY && c_off[11:2] == i[9:0])
                    regs[i] <= strb_merge(regs[i], c_data, c_strb);
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs_out[32*i +: 32] = regs[i];
    end
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb_axi4_lite_slave_regfile: directed vector table plus multi-cycle handshake sequences
module tb_axi4_lite_slave_regfile;
    import axi4_lite_pkg::*;
    localparam int NR = 16;

    logic              aclk = 1'b0, aresetn = 1'b0;
    logic [31:0]       awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [2:0]        awprot = '0, arprot = '0;
    logic [3:0]        wstrb = '0;
    logic              awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic              awready, wready, bvalid, arready, rvalid;
    logic [1:0]        bresp, rresp;
    logic [32*NR-1:0]  regs_out;
    logic [32*NR-1:0]  exp_regs;

    int n_cmp = 0, n_err = 0;

    axi4_lite_slave_regfile #(.BASE_ADDR(32'h0000_2000), .NUM_REGS(NR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_out(regs_out)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_w_ready(input string name);
        int t = 0;
        while (!(awready && wready) && t < 20) begin
            step();
            t++;
        end
        chk({name, "_wready_wait"}, {31'd0, awready && wready}, 32'd1);
    endtask

    task automatic wait_r_ready(input string name);
        int t = 0;
        while (!arready && t < 20) begin
            step();
            t++;
        end
        chk({name, "_arready_wait"}, {31'd0, arready}, 32'd1);
    endtask

    task automatic do_write(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er);
        wait_w_ready(name);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        chk({name, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        chk({name, "_bresp"}, {30'd0, bresp}, {30'd0, er});
        bready = 1;
        step();
        bready = 0;
        chk({name, "_bvalid_clr"}, {31'd0, bvalid}, 32'd0);
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] ed,
                           input logic [1:0] er);
        wait_r_ready(name);
        araddr = a; arvalid = 1;
        step();
        arvalid = 0;
        chk({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk({name, "_rdata"}, rdata, ed);
        chk({name, "_rresp"}, {30'd0, rresp}, {30'd0, er});
        rready = 1;
        step();
        rready = 0;
        chk({name, "_rvalid_clr"}, {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        v[0]  = '{0, 32'h2004, 32'h0,        4'h0, 32'h0000_0000, RESP_OKAY};
        v[1]  = '{1, 32'h2008, 32'hDEADBEEF, 4'hF, 32'hDEAD_BEEF, RESP_OKAY};
        v[2]  = '{0, 32'h2008, 32'h0,        4'h0, 32'hDEAD_BEEF, RESP_OKAY};
        v[3]  = '{1, 32'h2040, 32'h12345678, 4'hF, 32'h0000_0000, RESP_SLVERR};
        v[4]  = '{0, 32'h2040, 32'h0,        4'h0, 32'h0000_0000, RESP_SLVERR};
        v[5]  = '{0, 32'h4000, 32'h0,        4'h0, 32'h0000_0000, RESP_DECERR};
        v[6]  = '{1, 32'h1FFC, 32'hCAFEF00D, 4'hF, 32'h0000_0000, RESP_DECERR};
        v[7]  = '{1, 32'h203C, 32'hA5A5A5A5, 4'h3, 32'h0000_A5A5, RESP_OKAY};
        v[8]  = '{0, 32'h203C, 32'h0,        4'h0, 32'h0000_A5A5, RESP_OKAY};
        v[9]  = '{1, 32'h2008, 32'hFFFFFFFF, 4'h0, 32'hDEAD_BEEF, RESP_OKAY};
        v[10] = '{0, 32'h200A, 32'h0,        4'h0, 32'hDEAD_BEEF, RESP_OKAY};
        v[11] = '{1, 32'h3000, 32'h00000001, 4'hF, 32'h0000_0000, RESP_DECERR};
        v[12] = '{0, 32'h2FFC, 32'h0,        4'h0, 32'h0000_0000, RESP_SLVERR};
        v[13] = '{1, 32'h2000, 32'h01020304, 4'h8, 32'h0100_0000, RESP_OKAY};
        v[14] = '{0, 32'h2000, 32'h0,        4'h0, 32'h0100_0000, RESP_OKAY};

        // reset behaviour
        step();
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        step();
        aresetn = 1;
        #1;
        chk("release_wready_pre_edge", {31'd0, wready}, 32'd0);
        step();
        chk("rel_readys", {29'd0, awready, wready, arready}, 32'd7);
        chk("rel_valids", {30'd0, bvalid, rvalid}, 32'd0);
        chk("rel_resps", {28'd0, bresp, rresp}, 32'd0);
        chk("rel_rdata", rdata, 32'd0);
        chk("rel_regs_zero", {31'd0, regs_out == '0}, 32'd1);

        // vector table
        for (int i = 0; i < 15; i++) begin
            if (v[i].wr) begin
                do_write($sformatf("vec%0d", i), v[i].addr, v[i].data, v[i].strb, v[i].exp_resp);
                if (v[i].exp_resp == RESP_OKAY)
                    chk($sformatf("vec%0d_regs_out", i),
                        regs_out[32*((v[i].addr - 32'h2000) >> 2) +: 32], v[i].exp_data);
            end else begin
                do_read($sformatf("vec%0d", i), v[i].addr, v[i].exp_data, v[i].exp_resp);
            end
        end
        exp_regs = '0;
        exp_regs[32*0 +: 32]  = 32'h0100_0000;
        exp_regs[32*2 +: 32]  = 32'hDEAD_BEEF;
        exp_regs[32*15 +: 32] = 32'h0000_A5A5;
        chk("err_no_effect", {31'd0, regs_out == exp_regs}, 32'd1);

        // W before AW, partial strobes
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1;
        step();
        wvalid = 0;
        chk("wfirst_wready_low", {31'd0, wready}, 32'd0);
        chk("wfirst_awready_high", {31'd0, awready}, 32'd1);
        step(); step(); step();
        chk("wfirst_no_bvalid", {31'd0, bvalid}, 32'd0);
        chk("wfirst_reg_held", regs_out[32*2 +: 32], 32'hDEAD_BEEF);
        awaddr = 32'h2008; awvalid = 1;
        step();
        awvalid = 0;
        chk("wfirst_bvalid", {31'd0, bvalid}, 32'd1);
        chk("wfirst_bresp", {30'd0, bresp}, 32'd0);
        chk("wfirst_awready_resp", {31'd0, awready}, 32'd0);
        chk("wfirst_reg", regs_out[32*2 +: 32], 32'hDE22_BE44);

        // bready stalled while a second write is offered
        awaddr = 32'h2010; wdata = 32'h0000_0055; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_bvalid", i), {31'd0, bvalid}, 32'd1);
            chk($sformatf("stall%0d_bresp", i), {30'd0, bresp}, 32'd0);
            chk($sformatf("stall%0d_awready", i), {31'd0, awready}, 32'd0);
            step();
        end
        chk("stall_reg4_untouched", regs_out[32*4 +: 32], 32'd0);
        bready = 1;
        step();
        bready = 0;
        chk("stall_bvalid_drop", {31'd0, bvalid}, 32'd0);
        chk("stall_awready_back", {31'd0, awready}, 32'd1);
        step();
        awvalid = 0; wvalid = 0;
        chk("stall2_bvalid", {31'd0, bvalid}, 32'd1);
        chk("stall2_reg4", regs_out[32*4 +: 32], 32'h0000_0055);
        bready = 1;
        step();
        bready = 0;

        // same-cycle read and write of one register
        do_write("rw_pre", 32'h200C, 32'h1, 4'hF, RESP_OKAY);
        awaddr = 32'h200C; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'h200C; arvalid = 1;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("rw_rvalid", {31'd0, rvalid}, 32'd1);
        chk("rw_old_data", rdata, 32'h1);
        chk("rw_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
        do_read("rw_post", 32'h200C, 32'h2, RESP_OKAY);

        // reset while an address is pending
        awaddr = 32'h2014; awvalid = 1;
        step();
        awvalid = 0;
        chk("mid_have_addr", {30'd0, awready, wready}, 32'd1);
        aresetn = 0;
        #1;
        chk("mid_rst_wready", {31'd0, wready}, 32'd0);
        chk("mid_rst_regs", {31'd0, regs_out == '0}, 32'd1);
        step();
        aresetn = 1;
        step();
        wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1;
        step();
        wvalid = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mid_no_bvalid%0d", i), {31'd0, bvalid}, 32'd0);
            step();
        end
        chk("mid_no_commit", {31'd0, regs_out == '0}, 32'd1);
        chk("mid_have_data", {30'd0, awready, wready}, 32'd2);
        awaddr = 32'h2014; awvalid = 1;
        step();
        awvalid = 0;
        chk("mid_late_bvalid", {31'd0, bvalid}, 32'd1);
        chk("mid_late_reg5", regs_out[32*5 +: 32], 32'h7777_7777);
        bready = 1;
        step();
        bready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
